// File: rtl/cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_exc_ctrl
// System-control coprocessor register file (Status, Cause, EPC and, when the
// timer is built in, Count/Compare) plus the exception / interrupt / ERET
// sequencer that produces a one-cycle PC redirect pulse.
//
// Build option:
//   CP0_TIMER_EN  when defined, Count (reg 9) and Compare (reg 11) exist,
//                 Count increments every cycle and a Count==Compare match sets
//                 Cause.IP[7] (sticky, cleared by writing Compare).
//                 When undefined, regs 9/11 read 0, writes are dropped and
//                 IP[7] is 0.
//
// Ports:
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   cp0_wr          mtc0 write strobe, w_reg index, w_data value
//   r_reg / r_data  mfc0 index and combinational read of registered state
//   exc_req         synchronous exception request with exc_code, exc_pc,
//                   exc_bd (faulting instruction sits in a delay slot)
//   eret            ERET executing
//   irq             level-sensitive hardware interrupt lines
//   redirect        one-cycle PC override pulse, target on redirect_pc
//                   (redirect_pc is 0 whenever redirect is 0)
//   exl             Status.EXL mirror
//
// Register map: 12 Status{IM[15:8],EXL[1],IE[0]}
//               13 Cause{BD[31],IP[15:8],ExcCode[6:2]}
//               14 EPC, 9 Count, 11 Compare. Anything else reads 0.
// -----------------------------------------------------------------------------
module cp0_exc_ctrl #(
    parameter int                 DATA_W       = 32,
    parameter int                 NUM_IRQ      = 5,
    parameter logic [DATA_W-1:0]  EXC_VECTOR   = 32'h0000_0040,
    parameter logic [DATA_W-1:0]  RESET_STATUS = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cp0_wr,
    input  logic [4:0]          w_reg,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [4:0]          r_reg,
    output logic [DATA_W-1:0]   r_data,
    input  logic                exc_req,
    input  logic [4:0]          exc_code,
    input  logic [DATA_W-1:0]   exc_pc,
    input  logic                exc_bd,
    input  logic                eret,
    input  logic [NUM_IRQ-1:0]  irq,
    output logic                redirect,
    output logic [DATA_W-1:0]   redirect_pc,
    output logic                exl
);

    // The read word is assembled at least 32 bits wide so that Cause.BD keeps
    // its architectural position; narrower builds simply lose the top bits.
    localparam int RW = (DATA_W > 32) ? DATA_W : 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_r;
    logic                 redirect_r;
    logic [DATA_W-1:0]    redirect_pc_r;

    logic [7:0]           im_r;
    logic                 exl_r;
    logic                 ie_r;

    logic                 bd_r;
    logic [1:0]           ip_sw_r;
    logic [NUM_IRQ-1:0]   ip_hw_r;
    logic [4:0]           exc_code_r;

    logic [DATA_W-1:0]    epc_r;

    // Timer view used by the read mux and the interrupt logic
    logic [DATA_W-1:0]    count_val_s;
    logic [DATA_W-1:0]    compare_val_s;
    logic                 ip_timer_s;

    // ------------------------------------------------------------------
    // Decode / next-state signals
    // ------------------------------------------------------------------
    logic                 wr_status_s;
    logic                 wr_cause_s;
    logic                 wr_epc_s;
    logic                 wr_count_s;
    logic                 wr_compare_s;
    logic                 idle_s;
    logic [7:0]           ip_s;
    logic                 int_take_s;
    logic                 take_exc_s;
    logic                 take_int_s;
    logic                 take_eret_s;
    logic                 entry_s;
    logic [DATA_W-1:0]    epc_nxt_s;
    logic [RW-1:0]        r_word_s;

    // Write-port decode
    always_comb begin
        wr_status_s  = cp0_wr & (w_reg == 5'd12);
        wr_cause_s   = cp0_wr & (w_reg == 5'd13);
        wr_epc_s     = cp0_wr & (w_reg == 5'd14);
        wr_count_s   = cp0_wr & (w_reg == 5'd9);
        wr_compare_s = cp0_wr & (w_reg == 5'd11);
    end

    // Pending-interrupt vector as seen in Cause.IP
    always_comb begin
        ip_s                = 8'h00;
        ip_s[1:0]           = ip_sw_r;
        ip_s[NUM_IRQ+1:2]   = ip_hw_r;
        ip_s[7]             = ip_timer_s;
    end

    // Event arbitration: only the IDLE state accepts events, exception first
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        int_take_s  = ie_r & ~exl_r & (|(ip_s & im_r)) & idle_s;
        take_exc_s  = idle_s & exc_req;
        take_int_s  = ~take_exc_s & int_take_s;
        take_eret_s = idle_s & ~exc_req & ~int_take_s & eret;
        entry_s     = take_exc_s | take_int_s;
    end

    // EPC next value; hardware capture beats a same-cycle mtc0. A nested
    // exception (EXL already set) must keep the original return address.
    always_comb begin
        epc_nxt_s = epc_r;
        if (entry_s && !exl_r) begin
            epc_nxt_s = exc_pc;
        end else if (wr_epc_s) begin
            epc_nxt_s = w_data;
        end else begin
            epc_nxt_s = epc_r;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered redirect outputs
    // ------------------------------------------------------------------
    // FSM: IDLE accepts one event, ENTER/RETURN each drive redirect for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            redirect_r    <= 1'b0;
            redirect_pc_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (entry_s) begin
                        state_r       <= ST_ENTER;
                        redirect_r    <= 1'b1;
                        redirect_pc_r <= EXC_VECTOR;
                    end else if (take_eret_s) begin
                        state_r       <= ST_RETURN;
                        redirect_r    <= 1'b1;
                        redirect_pc_r <= epc_nxt_s;
                    end else begin
                        state_r       <= ST_IDLE;
                        redirect_r    <= 1'b0;
                        redirect_pc_r <= '0;
                    end
                end
                ST_ENTER, ST_RETURN: begin
                    state_r       <= ST_IDLE;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= '0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    // Status: IM/IE from software, EXL owned by hardware when both touch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_r  <= RESET_STATUS[15:8];
            exl_r <= RESET_STATUS[1];
            ie_r  <= RESET_STATUS[0];
        end else begin
            if (wr_status_s) begin
                im_r <= w_data[15:8];
                ie_r <= w_data[0];
            end else begin
                im_r <= im_r;
                ie_r <= ie_r;
            end
            if (entry_s) begin
                exl_r <= 1'b1;
            end else if (take_eret_s) begin
                exl_r <= 1'b0;
            end else if (wr_status_s) begin
                exl_r <= w_data[1];
            end else begin
                exl_r <= exl_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cause and EPC
    // ------------------------------------------------------------------
    // Cause: BD/ExcCode captured on entry, IP[1:0] software, IP[hw] sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bd_r       <= 1'b0;
            ip_sw_r    <= 2'b00;
            ip_hw_r    <= '0;
            exc_code_r <= 5'd0;
        end else begin
            ip_hw_r <= irq;
            if (wr_cause_s) begin
                ip_sw_r <= w_data[9:8];
            end else begin
                ip_sw_r <= ip_sw_r;
            end
            if (entry_s && !exl_r) begin
                bd_r <= exc_bd;
            end else begin
                bd_r <= bd_r;
            end
            if (take_exc_s) begin
                exc_code_r <= exc_code;
            end else if (take_int_s) begin
                exc_code_r <= 5'd0;
            end else begin
                exc_code_r <= exc_code_r;
            end
        end
    end

    // EPC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_r <= '0;
        end else begin
            epc_r <= epc_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Optional timer
    // ------------------------------------------------------------------
`ifdef CP0_TIMER_EN
    logic [DATA_W-1:0] count_r;
    logic [DATA_W-1:0] compare_r;
    logic              ip_timer_r;

    // Count/Compare and the sticky timer interrupt; a match beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= '0;
            compare_r  <= '0;
            ip_timer_r <= 1'b0;
        end else begin
            if (wr_count_s) begin
                count_r <= w_data;
            end else begin
                count_r <= count_r + {{(DATA_W-1){1'b0}}, 1'b1};
            end
            if (wr_compare_s) begin
                compare_r <= w_data;
            end else begin
                compare_r <= compare_r;
            end
            if (count_r == compare_r) begin
                ip_timer_r <= 1'b1;
            end else if (wr_compare_s) begin
                ip_timer_r <= 1'b0;
            end else begin
                ip_timer_r <= ip_timer_r;
            end
        end
    end

    // Timer view for the read path
    always_comb begin
        count_val_s   = count_r;
        compare_val_s = compare_r;
        ip_timer_s    = ip_timer_r;
    end
`else
    // No timer: regs 9/11 read as zero and writes to them are dropped
    always_comb begin
        count_val_s   = '0;
        compare_val_s = '0;
        ip_timer_s    = 1'b0 & wr_count_s & wr_compare_s;
    end
`endif

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    // mfc0 read mux over registered state (no write bypass)
    always_comb begin
        r_word_s = '0;
        case (r_reg)
            5'd12: begin
                r_word_s[15:8] = im_r;
                r_word_s[1]    = exl_r;
                r_word_s[0]    = ie_r;
            end
            5'd13: begin
                r_word_s[31]   = bd_r;
                r_word_s[15:8] = ip_s;
                r_word_s[6:2]  = exc_code_r;
            end
            5'd14:   r_word_s[DATA_W-1:0] = epc_r;
            5'd9:    r_word_s[DATA_W-1:0] = count_val_s;
            5'd11:   r_word_s[DATA_W-1:0] = compare_val_s;
            default: r_word_s = '0;
        endcase
    end

    assign r_data      = r_word_s[DATA_W-1:0];
    assign redirect    = redirect_r;
    assign redirect_pc = redirect_pc_r;
    assign exl         = exl_r;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_exc_ctrl
// Table-driven bench for cp0_exc_ctrl (default parameters). Each table row is
// one clock: inputs applied before the edge, expected outputs (redirect,
// redirect_pc, exl and r_data for the row's r_reg) observed after it.
// Expectations are queued when a row is driven and popped after the edge.
// Hand-written sequences cover reset values, reset during ENTER and the timer.
// -----------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cp0_wr;
    logic [4:0]  w_reg;
    logic [31:0] w_data;
    logic [4:0]  r_reg;
    logic [31:0] r_data;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic [4:0]  irq;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exl;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic        er;
        logic [4:0]  irqv;
        logic [4:0]  rreg;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_exl;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    cp0_exc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cp0_wr      (cp0_wr),
        .w_reg       (w_reg),
        .w_data      (w_data),
        .r_reg       (r_reg),
        .r_data      (r_data),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .exc_bd      (exc_bd),
        .eret        (eret),
        .irq         (irq),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exl         (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic wr, input logic [4:0] wreg, input logic [31:0] wdata,
        input logic exc, input logic [4:0] code, input logic [31:0] pc,
        input logic bd, input logic er, input logic [4:0] irqv,
        input logic [4:0] rreg, input logic e_redir, input logic [31:0] e_rpc,
        input logic e_exl, input logic [31:0] e_rdata);
        vec_t v;
        v.wr = wr; v.wreg = wreg; v.wdata = wdata;
        v.exc = exc; v.code = code; v.pc = pc; v.bd = bd;
        v.er = er; v.irqv = irqv; v.rreg = rreg;
        v.e_redir = e_redir; v.e_rpc = e_rpc; v.e_exl = e_exl; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cp0_wr   = v.wr;
        w_reg    = v.wreg;
        w_data   = v.wdata;
        exc_req  = v.exc;
        exc_code = v.code;
        exc_pc   = v.pc;
        exc_bd   = v.bd;
        eret     = v.er;
        irq      = v.irqv;
        r_reg    = v.rreg;
    endtask

    task automatic idle_inputs(input logic [4:0] rr);
        drive(mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, rr,
                 1'b0, 32'h0, 1'b0, 32'h0));
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        drive(mk(1'b1, idx, val, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd13,
                 1'b0, 32'h0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        idle_inputs(5'd13);
    endtask

    initial begin
        vec_t exp_v;
        bit   seen;

        rst_n = 1'b0;
        idle_inputs(5'd12);

        // ---------------- Reset values (read while reset held) ----------------
        repeat (2) @(posedge clk);
        #1;
        r_reg = 5'd12; #1 check("reset status", r_data, 32'h0000_0000);
        r_reg = 5'd13; #1 check("reset cause", r_data, 32'h0000_0000);
        r_reg = 5'd14; #1 check("reset epc", r_data, 32'h0000_0000);
        check("reset redirect", {31'd0, redirect}, 32'd0);
        check("reset redirect_pc", redirect_pc, 32'h0);
        check("reset exl", {31'd0, exl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef CP0_TIMER_EN
        // ---------------- Vector table ----------------
        //            wr    wreg   wdata          exc   code   pc            bd    eret  irq    rreg   redir rpc           exl   rdata
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd12, 1'b0, 32'h0,        1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd13, 1'b0, 32'h0,        1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd14, 1'b0, 32'h0,        1'b0, 32'h0));
        // exception code 4, delay slot
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h100,      1'b1, 1'b0, 5'd0,  5'd14, 1'b1, 32'h40,       1'b1, 32'h100));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd13, 1'b0, 32'h0,        1'b1, 32'h8000_0010));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  5'd12, 1'b1, 32'h100,      1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd14, 1'b0, 32'h0,        1'b0, 32'h100));
        // hardware interrupt on irq[0]
        tbl.push_back(mk(1'b1, 5'd12, 32'h401,      1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd12, 1'b0, 32'h0,        1'b0, 32'h401));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd1,  5'd13, 1'b0, 32'h0,        1'b0, 32'h8000_0410));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h500,      1'b0, 1'b0, 5'd1,  5'd13, 1'b1, 32'h40,       1'b1, 32'h400));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd1,  5'd14, 1'b0, 32'h0,        1'b1, 32'h500));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd3,  5'd12, 1'b0, 32'h0,        1'b1, 32'h403));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd3,  5'd13, 1'b0, 32'h0,        1'b1, 32'hC00));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd13, 1'b0, 32'h0,        1'b1, 32'h0));
        // EPC write then ERET
        tbl.push_back(mk(1'b1, 5'd14, 32'h200,      1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd14, 1'b0, 32'h0,        1'b1, 32'h200));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  5'd12, 1'b1, 32'h200,      1'b0, 32'h401));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd12, 1'b0, 32'h0,        1'b0, 32'h401));
        // ERET uses EPC value written in the same cycle; ERET in RETURN ignored
        tbl.push_back(mk(1'b1, 5'd14, 32'h280,      1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  5'd14, 1'b1, 32'h280,      1'b0, 32'h280));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  5'd12, 1'b0, 32'h0,        1'b0, 32'h401));
        // EPC write + exception + ERET in one cycle: exception wins, hw EPC wins
        tbl.push_back(mk(1'b1, 5'd14, 32'hDEAD,     1'b1, 5'd12, 32'h300,      1'b0, 1'b1, 5'd0,  5'd14, 1'b1, 32'h40,       1'b1, 32'h300));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd13, 1'b0, 32'h0,        1'b1, 32'h30));
        // nested exception: EPC/BD kept, ExcCode updated; exc in ENTER ignored
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h900,      1'b1, 1'b0, 5'd0,  5'd14, 1'b1, 32'h40,       1'b1, 32'h300));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h0,        1'b0, 1'b0, 5'd0,  5'd13, 1'b0, 32'h0,        1'b1, 32'h28));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  5'd12, 1'b1, 32'h300,      1'b0, 32'h401));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd12, 1'b0, 32'h0,        1'b0, 32'h401));
        // Status write with exception: EXL from hardware, IM/IE from write
        tbl.push_back(mk(1'b1, 5'd12, 32'hFF00,     1'b1, 5'd3,  32'h700,      1'b0, 1'b0, 5'd0,  5'd12, 1'b1, 32'h40,       1'b1, 32'hFF02));
        tbl.push_back(mk(1'b1, 5'd13, 32'h300,      1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd13, 1'b0, 32'h0,        1'b1, 32'h30C));
        // unmapped and absent-timer registers
        tbl.push_back(mk(1'b1, 5'd5,  32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0,  5'd5,  1'b0, 32'h0,        1'b1, 32'h0));
        tbl.push_back(mk(1'b1, 5'd9,  32'h1234,     1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd9,  1'b0, 32'h0,        1'b1, 32'h0));
        tbl.push_back(mk(1'b1, 5'd11, 32'h55,       1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd11, 1'b0, 32'h0,        1'b1, 32'h0));
        // software interrupt IP[0]
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd0,  5'd14, 1'b1, 32'h700,      1'b0, 32'h700));
        tbl.push_back(mk(1'b1, 5'd12, 32'h101,      1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd12, 1'b0, 32'h0,        1'b0, 32'h101));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h800,      1'b0, 1'b0, 5'd0,  5'd13, 1'b1, 32'h40,       1'b1, 32'h300));
        tbl.push_back(mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  5'd14, 1'b0, 32'h0,        1'b1, 32'h800));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            exp_v = sb.pop_front();
            check($sformatf("row%0d redirect", i), {31'd0, redirect}, {31'd0, exp_v.e_redir});
            check($sformatf("row%0d redirect_pc", i), redirect_pc, exp_v.e_rpc);
            check($sformatf("row%0d exl", i), {31'd0, exl}, {31'd0, exp_v.e_exl});
            check($sformatf("row%0d r_data", i), r_data, exp_v.e_rdata);
        end
        check("scoreboard drained", sb.size(), 32'd0);
`else
        // ---------------- Timer interrupt ----------------
        write_reg(5'd9, 32'd100);          // move Count away from Compare
        write_reg(5'd11, 32'd10);          // Compare=10, clears IP[7]
        r_reg = 5'd13; #1 check("timer ip7 cleared", r_data & 32'h8000, 32'h0);
        write_reg(5'd9, 32'd0);
        write_reg(5'd12, 32'h8001);        // IM[7]=1, IE=1
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (redirect) seen = 1'b1;
        end
        check("timer irq taken", {31'd0, seen}, 32'd1);
        check("timer redirect_pc", redirect_pc, 32'h40);
        check("timer exl", {31'd0, exl}, 32'd1);
        r_reg = 5'd13; #1 check("timer cause", r_data, 32'h0000_8000);
        r_reg = 5'd9;  #1 check("timer count", r_data, 32'd12);
        write_reg(5'd11, 32'h50);
        r_reg = 5'd13; #1 check("timer ip7 clear on compare", r_data, 32'h0);
`endif

        // ---------------- Reset during ENTER ----------------
        @(negedge clk);
        drive(mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h111, 1'b0, 1'b0, 5'd0, 5'd12,
                 1'b0, 32'h0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        idle_inputs(5'd12);
        check("pre-reset redirect", {31'd0, redirect}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset redirect", {31'd0, redirect}, 32'd0);
        check("async reset redirect_pc", redirect_pc, 32'h0);
        check("async reset exl", {31'd0, exl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset redirect", {31'd0, redirect}, 32'd0);
        check("post-reset status", r_data, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
